// File: rtl/color_pkg.sv
// Shared color-index constants and press-FSM state type, used by the button
// controller and by the RGB LED driver.
package color_pkg;

    localparam logic [2:0] RED     = 3'd0;
    localparam logic [2:0] YELLOW  = 3'd1;
    localparam logic [2:0] GREEN   = 3'd2;
    localparam logic [2:0] CYAN    = 3'd3;
    localparam logic [2:0] BLUE    = 3'd4;
    localparam logic [2:0] MAGENTA = 3'd5;

    localparam int unsigned NUM_COLORS_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        WAIT_RELEASE
    } press_state_t;

    // Explicit compare against the last index so non-power-of-2 counts wrap correctly.
    function automatic logic [2:0] color_next(input logic [2:0] idx, input int unsigned num);
        return (idx == 3'(num - 1)) ? RED : idx + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for a mechanical button.
// btn_level is the accepted pressed level (1 = pressed) regardless of pin polarity.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int   CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic PIN_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pressed;
    logic             w_differs;
    logic             w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= PIN_IDLE;
            r_sync2 <= PIN_IDLE;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_differs = (w_pressed != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Any cycle where the levels agree restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= w_pressed;
        end else if (w_differs) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt   <= '0;
        end
    end

    assign btn_level = r_level;

endmodule

// File: rtl/button_color_ctrl.sv
// Pushbutton front end for the RGB LED driver: short press steps the color
// index, long press returns it to RED; color_valid marks each update.
module button_color_ctrl
    import color_pkg::*;
#(
    parameter int unsigned CLK_HZ            = 12000000,
    parameter int unsigned DEBOUNCE_CYCLES   = 120000,
    parameter int unsigned LONG_PRESS_CYCLES = 6000000,
    parameter int unsigned NUM_COLORS        = NUM_COLORS_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       short_press,
    output logic       long_press,
    output logic [2:0] color_idx,
    output logic       color_valid
);

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

    if (CLK_HZ == 0 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES
        || NUM_COLORS < 1 || NUM_COLORS > 8) begin : g_bad_params
        $error("button_color_ctrl: illegal parameter combination");
    end

    press_state_t      r_state;
    press_state_t      w_next_state;
    logic [HOLD_W-1:0] r_hold;
    logic              w_level;
    logic              w_hold_done;
    logic              w_short_evt;
    logic              w_long_evt;
    logic              r_short;
    logic              r_long;
    logic              r_valid;
    logic [2:0]        r_idx;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (w_level)
    );

    assign w_hold_done = (r_hold == HOLD_W'(LONG_PRESS_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:         if (w_level) w_next_state = PRESSED;
            PRESSED: begin
                if (w_long_evt) begin
                    w_next_state = WAIT_RELEASE;
                end else if (w_short_evt) begin
                    w_next_state = IDLE;
                end
            end
            WAIT_RELEASE: if (!w_level) w_next_state = IDLE;
            default:      w_next_state = IDLE;
        endcase
    end

    // Threshold is checked first so a release in the threshold cycle is still long.
    always_comb begin
        w_long_evt  = 1'b0;
        w_short_evt = 1'b0;
        if (r_state == PRESSED) begin
            w_long_evt  = w_hold_done;
            w_short_evt = !w_hold_done && !w_level;
        end
    end

    // Hold counter sits at 0 outside PRESSED, so entry always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == PRESSED) begin
            r_hold <= r_hold + HOLD_W'(1);
        end else begin
            r_hold <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= RED;
        end else begin
            r_short <= w_short_evt;
            r_long  <= w_long_evt;
            r_valid <= w_short_evt || w_long_evt;
            if (w_long_evt) begin
                r_idx <= RED;
            end else if (w_short_evt) begin
                r_idx <= color_next(r_idx, NUM_COLORS);
            end
        end
    end

    assign btn_level   = w_level;
    assign short_press = r_short;
    assign long_press  = r_long;
    assign color_valid = r_valid;
    assign color_idx   = r_idx;

endmodule
